// File: rtl/alib_cartesian_to_spherical_cordic.sv
// Cartesian (x, y, z) to spherical (range, azimuth, elevation) converter.
// Two sequential CORDIC vectoring passes share one micro-rotation datapath:
// pass 1 rotates (y, x) to get azimuth and the xy-projection length, and
// pass 2 rotates (rho, z) to get range and elevation.
module alib_cartesian_to_spherical_cordic #(
  parameter int unsigned N_ITER = 16,
  parameter int unsigned GUARD  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic signed [15:0] i_x,
  input  logic signed [15:0] i_y,
  input  logic signed [15:0] i_z,
  input  logic               i_valid,
  output logic               o_ready,
  output logic        [15:0] o_range,
  output logic signed [15:0] o_azimuth,
  output logic signed [15:0] o_elevation,
  output logic               o_valid,
  input  logic               i_ready
);

  localparam int unsigned W  = 18 + GUARD;
  localparam int unsigned PW = W + 17;

  // 1/K in Q15, plus rounding offsets for the Q15 and guard-bit shifts
  localparam logic signed [PW-1:0] KInv   = PW'(19898);
  localparam logic signed [PW-1:0] RndQ15 = PW'(16384);
  localparam logic signed [PW-1:0] RndG   = PW'(1 << (GUARD - 1));

  typedef enum logic [2:0] {
    StIdle, StIter1, StComp1, StIter2, StComp2, StDone
  } state_e;

  // atan(2^-i) in BAM, 32768 = pi
  function automatic logic signed [15:0] atan_lut(input logic [4:0] idx);
    logic signed [15:0] v;
    case (idx)
      5'd0:    v = 16'sd8192;
      5'd1:    v = 16'sd4836;
      5'd2:    v = 16'sd2555;
      5'd3:    v = 16'sd1297;
      5'd4:    v = 16'sd651;
      5'd5:    v = 16'sd326;
      5'd6:    v = 16'sd163;
      5'd7:    v = 16'sd81;
      5'd8:    v = 16'sd41;
      5'd9:    v = 16'sd20;
      5'd10:   v = 16'sd10;
      5'd11:   v = 16'sd5;
      5'd12:   v = 16'sd3;
      5'd13:   v = 16'sd1;
      5'd14:   v = 16'sd1;
      default: v = 16'sd0;
    endcase
    return v;
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic signed [W-1:0] xc_q, xc_d, yc_q, yc_d;
  logic signed [15:0] z_q, z_d;
  logic signed [15:0] zin_q, zin_d;
  logic               xy_zero_q, xy_zero_d, all_zero_q, all_zero_d;
  logic        [15:0] range_q, range_d;
  logic signed [15:0] az_q, az_d, el_q, el_d;

  logic signed [W-1:0]  xs, ys, y_in, x_in;
  logic signed [PW-1:0] prod, rho_full;
  logic signed [15:0]   atan_i;

  // Next-state, micro-rotation and gain-compensation logic
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    z_d        = z_q;
    zin_d      = zin_q;
    xy_zero_d  = xy_zero_q;
    all_zero_d = all_zero_q;
    range_d    = range_q;
    az_d       = az_q;
    el_d       = el_q;

    xs       = xc_q >>> iter_q;
    ys       = yc_q >>> iter_q;
    atan_i   = atan_lut(iter_q);
    y_in     = W'(i_y) <<< GUARD;
    x_in     = W'(i_x) <<< GUARD;
    prod     = PW'(xc_q) * KInv;
    rho_full = (prod + RndQ15) >>> 15;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          // Left half-plane: rotate by pi so vectoring converges
          if (i_y[15]) begin
            xc_d = -y_in;
            yc_d = -x_in;
            z_d  = -16'sd32768;
          end else begin
            xc_d = y_in;
            yc_d = x_in;
            z_d  = 16'sd0;
          end
          zin_d      = i_z;
          xy_zero_d  = (i_x == 16'sd0) && (i_y == 16'sd0);
          all_zero_d = (i_x == 16'sd0) && (i_y == 16'sd0) && (i_z == 16'sd0);
          iter_d     = 5'd0;
          state_d    = StIter1;
        end
      end
      StIter1, StIter2: begin
        if (!yc_q[W-1]) begin
          xc_d = xc_q + ys;
          yc_d = yc_q - xs;
          z_d  = z_q + atan_i;
        end else begin
          xc_d = xc_q - ys;
          yc_d = yc_q + xs;
          z_d  = z_q - atan_i;
        end
        if (iter_q == 5'(N_ITER - 1)) begin
          iter_d  = 5'd0;
          state_d = (state_q == StIter1) ? StComp1 : StComp2;
        end else begin
          iter_d = iter_q + 5'd1;
        end
      end
      StComp1: begin
        az_d    = xy_zero_q ? 16'sd0 : z_q;
        xc_d    = W'(rho_full);
        yc_d    = W'(zin_q) <<< GUARD;
        z_d     = 16'sd0;
        state_d = StIter2;
      end
      StComp2: begin
        el_d    = all_zero_q ? 16'sd0 : z_q;
        range_d = 16'((rho_full + RndG) >>> GUARD);
        state_d = StDone;
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      iter_q     <= '0;
      xc_q       <= '0;
      yc_q       <= '0;
      z_q        <= '0;
      zin_q      <= '0;
      xy_zero_q  <= 1'b0;
      all_zero_q <= 1'b0;
      range_q    <= '0;
      az_q       <= '0;
      el_q       <= '0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      z_q        <= z_d;
      zin_q      <= zin_d;
      xy_zero_q  <= xy_zero_d;
      all_zero_q <= all_zero_d;
      range_q    <= range_d;
      az_q       <= az_d;
      el_q       <= el_d;
    end
  end

  assign o_ready     = (state_q == StIdle);
  assign o_valid     = (state_q == StDone);
  assign o_range     = range_q;
  assign o_azimuth   = az_q;
  assign o_elevation = el_q;

endmodule

// File: tb/tb_alib_cartesian_to_spherical_cordic.sv
// Scoreboard bench for the Cartesian-to-spherical CORDIC converter.
module tb_alib_cartesian_to_spherical_cordic;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic signed [15:0] i_x, i_y, i_z;
  logic               i_valid;
  logic               o_ready;
  logic        [15:0] o_range;
  logic signed [15:0] o_azimuth, o_elevation;
  logic               o_valid;
  logic               i_ready;

  alib_cartesian_to_spherical_cordic #(
    .N_ITER(16),
    .GUARD (4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_x        (i_x),
    .i_y        (i_y),
    .i_z        (i_z),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_range    (o_range),
    .o_azimuth  (o_azimuth),
    .o_elevation(o_elevation),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int id;
    int r;
    int az;
    int el;
    int tr;
    int ta;
    int te;
    bit wrap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t mk(input int id, input int r, input int az, input int el,
                              input int tr, input int ta, input int te, input bit wrap);
    exp_t e;
    e.id = id; e.r = r; e.az = az; e.el = el;
    e.tr = tr; e.ta = ta; e.te = te; e.wrap = wrap;
    return e;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: latency of each result and scoreboard compare on each output handshake
  initial begin : monitor
    int   acc_cyc;
    bit   prev_valid;
    exp_t e;
    int   r, az, el;
    bit   ok;
    acc_cyc    = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_valid = 1'b0;
      end else begin
        if (i_valid && o_ready) acc_cyc = cyc;
        if (o_valid && !prev_valid)
          check("latency", (cyc - acc_cyc) == 35, cyc - acc_cyc, 35);
        if (o_valid && i_ready) begin
          if (sbq.size() == 0) begin
            check("unexpected_output", 1'b0, int'(o_range), -1);
          end else begin
            e  = sbq.pop_front();
            r  = int'(o_range);
            az = int'($signed(o_azimuth));
            el = int'($signed(o_elevation));
            check($sformatf("v%0d_range", e.id), iabs(r - e.r) <= e.tr, r, e.r);
            if (e.wrap) ok = (az >= 32764) || (az <= -32764);
            else        ok = iabs(az - e.az) <= e.ta;
            check($sformatf("v%0d_azimuth", e.id), ok, az, e.az);
            check($sformatf("v%0d_elevation", e.id), iabs(el - e.el) <= e.te, el, e.el);
          end
        end
        prev_valid = o_valid;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog actual timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at #1 after a posedge; returns at #1 after the accepting posedge
  task automatic send(input int x, input int y, input int z, input exp_t e, input bit push);
    int n;
    n = 0;
    while (!o_ready && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("send_ready", o_ready, int'(o_ready), 1);
    i_x = 16'(x);
    i_y = 16'(y);
    i_z = 16'(z);
    i_valid = 1'b1;
    if (push) sbq.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("drain", sbq.size() == 0, sbq.size(), 0);
  endtask

  initial begin : stim
    int   n;
    int   r0, a0, e0;
    bit   stray;
    exp_t none;
    none    = mk(0, 0, 0, 0, 0, 0, 0, 1'b0);
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_x = '0; i_y = '0; i_z = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid == 1'b0, int'(o_valid), 0);
    check("rst_ready", o_ready == 1'b1, int'(o_ready), 1);
    check("rst_range", o_range == 16'd0, int'(o_range), 0);
    check("rst_az", o_azimuth == 16'sd0, int'(o_azimuth), 0);
    check("rst_el", o_elevation == 16'sd0, int'(o_elevation), 0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    send(0, 1000, 0, mk(1, 1000, 0, 0, 2, 4, 4, 1'b0), 1'b1);
    send(1000, 0, 0, mk(2, 1000, 16384, 0, 2, 4, 4, 1'b0), 1'b1);
    send(0, -1000, 0, mk(3, 1000, 32767, 0, 2, 4, 4, 1'b1), 1'b1);
    send(0, 0, -500, mk(4, 500, 0, -16384, 2, 0, 4, 1'b0), 1'b1);
    send(0, 0, 0, mk(5, 0, 0, 0, 0, 0, 0, 1'b0), 1'b1);
    send(300, 400, 1200, mk(6, 1300, 6712, 12266, 2, 4, 4, 1'b0), 1'b1);
    send(-32768, -32768, -32768, mk(7, 56755, -24576, -6420, 2, 4, 4, 1'b0), 1'b1);
    drain();

    // Backpressure: hold i_ready low for 10 cycles with a stray i_valid pulse
    i_ready = 1'b0;
    send(-1000, 0, 200, mk(8, 1020, -16384, 2059, 2, 4, 4, 1'b0), 1'b1);
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("bp_valid_seen", o_valid, int'(o_valid), 1);
    r0 = int'(o_range);
    a0 = int'(o_azimuth);
    e0 = int'(o_elevation);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        i_x = 16'sd5; i_y = 16'sd7; i_z = 16'sd9;
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge i_clk);
      #1;
      check("bp_range_stable", int'(o_range) == r0, int'(o_range), r0);
      check("bp_az_stable", int'(o_azimuth) == a0, int'(o_azimuth), a0);
      check("bp_el_stable", int'(o_elevation) == e0, int'(o_elevation), e0);
      check("bp_valid_held", o_valid == 1'b1, int'(o_valid), 1);
      check("bp_ready_low", o_ready == 1'b0, int'(o_ready), 0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("bp_valid_drop", o_valid == 1'b0, int'(o_valid), 0);
    check("bp_ready_back", o_ready == 1'b1, int'(o_ready), 1);
    check("bp_range_kept", int'(o_range) == r0, int'(o_range), r0);
    stray = 1'b0;
    repeat (40) begin
      @(posedge i_clk);
      #1;
      if (o_valid) stray = 1'b1;
    end
    check("bp_no_capture", stray == 1'b0, int'(stray), 0);
    drain();

    // Reset in the middle of ITER1 discards the in-flight vector
    send(1000, 1000, 1000, none, 1'b0);
    repeat (7) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("mid_rst_valid", o_valid == 1'b0, int'(o_valid), 0);
    check("mid_rst_ready", o_ready == 1'b1, int'(o_ready), 1);
    check("mid_rst_range", o_range == 16'd0, int'(o_range), 0);
    check("mid_rst_az", o_azimuth == 16'sd0, int'(o_azimuth), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    send(300, 400, 1200, mk(9, 1300, 6712, 12266, 2, 4, 4, 1'b0), 1'b1);
    drain();

    repeat (5) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
